// File: rtl/csr_file.sv
// ============================================================================
// Module  : csr_file
// Brief   : Machine-mode CSR file with trap entry, WARL masking, 64-bit
//           cycle/instret counters and same-cycle write-back read bypass.
// Revision: 1.0
// ============================================================================
`default_nettype none

module csr_file #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = '0,
    parameter int              HART_ID   = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [11:0]     csr_rd_adr_i,
    output logic [XLEN-1:0] csr_rd_data_o,
    output logic            csr_rd_illegal_o,
    input  logic            csr_wbk_v_q_i,
    input  logic [11:0]     csr_adr_q_i,
    input  logic [XLEN-1:0] csr_data_q_i,
    input  logic            exception_q_i,
    input  logic [XLEN-1:0] mcause_q_i,
    input  logic [XLEN-1:0] mtval_q_i,
    input  logic [XLEN-1:0] mepc_q_i,
    input  logic [1:0]      core_mode_q_i,
    input  logic            instret_v_i,
    output logic [XLEN-1:0] mepc_q_o,
    output logic [XLEN-1:0] mtvec_q_o,
    output logic [XLEN-1:0] mstatus_q_o
);

    localparam logic [11:0] c_ADR_MSTATUS   = 12'h300;
    localparam logic [11:0] c_ADR_MISA      = 12'h301;
    localparam logic [11:0] c_ADR_MIE       = 12'h304;
    localparam logic [11:0] c_ADR_MTVEC     = 12'h305;
    localparam logic [11:0] c_ADR_MSCRATCH  = 12'h340;
    localparam logic [11:0] c_ADR_MEPC      = 12'h341;
    localparam logic [11:0] c_ADR_MCAUSE    = 12'h342;
    localparam logic [11:0] c_ADR_MTVAL     = 12'h343;
    localparam logic [11:0] c_ADR_MIP       = 12'h344;
    localparam logic [11:0] c_ADR_MCYCLE    = 12'hB00;
    localparam logic [11:0] c_ADR_MINSTRET  = 12'hB02;
    localparam logic [11:0] c_ADR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] c_ADR_MINSTRETH = 12'hB82;
    localparam logic [11:0] c_ADR_MHARTID   = 12'hF14;

    localparam logic [XLEN-1:0] c_MSTATUS_MASK = XLEN'(32'h0000_1888);
    localparam logic [XLEN-1:0] c_MSTATUS_RST  = XLEN'(32'h0000_1800);
    localparam logic [XLEN-1:0] c_MIE_MASK     = XLEN'(32'h0000_0888);
    localparam logic [XLEN-1:0] c_ALIGN_MASK   = ~(XLEN'(3));
    localparam logic [XLEN-1:0] c_MISA_VAL     = XLEN'(32'h4000_0100);
    localparam logic [XLEN-1:0] c_HART_ID_VAL  = XLEN'(HART_ID);

    logic [XLEN-1:0] r_mstatus;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mie;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;
    logic [63:0]     r_mcycle;
    logic [63:0]     r_minstret;

    logic            w_we_mstatus;
    logic            w_we_mie;
    logic            w_we_mtvec;
    logic            w_we_mscratch;
    logic            w_we_mepc;
    logic            w_we_mcause;
    logic            w_we_mtval;
    logic            w_we_mcycle;
    logic            w_we_mcycleh;
    logic            w_we_minstret;
    logic            w_we_minstreth;
    logic [XLEN-1:0] w_mstatus_trap;
    logic [XLEN-1:0] w_rd_stored;
    logic            w_rd_illegal;
    logic [XLEN-1:0] w_wb_masked;
    logic            w_wb_writable;
    logic            w_bypass_hit;

    // Trap-owned registers lose a same-cycle software write to the trap update.
    assign w_we_mstatus   = csr_wbk_v_q_i && (csr_adr_q_i == c_ADR_MSTATUS) && !exception_q_i;
    assign w_we_mepc      = csr_wbk_v_q_i && (csr_adr_q_i == c_ADR_MEPC)    && !exception_q_i;
    assign w_we_mcause    = csr_wbk_v_q_i && (csr_adr_q_i == c_ADR_MCAUSE)  && !exception_q_i;
    assign w_we_mtval     = csr_wbk_v_q_i && (csr_adr_q_i == c_ADR_MTVAL)   && !exception_q_i;
    assign w_we_mie       = csr_wbk_v_q_i && (csr_adr_q_i == c_ADR_MIE);
    assign w_we_mtvec     = csr_wbk_v_q_i && (csr_adr_q_i == c_ADR_MTVEC);
    assign w_we_mscratch  = csr_wbk_v_q_i && (csr_adr_q_i == c_ADR_MSCRATCH);
    assign w_we_mcycle    = csr_wbk_v_q_i && (csr_adr_q_i == c_ADR_MCYCLE);
    assign w_we_mcycleh   = csr_wbk_v_q_i && (csr_adr_q_i == c_ADR_MCYCLEH);
    assign w_we_minstret  = csr_wbk_v_q_i && (csr_adr_q_i == c_ADR_MINSTRET);
    assign w_we_minstreth = csr_wbk_v_q_i && (csr_adr_q_i == c_ADR_MINSTRETH);

    always_comb begin
        w_mstatus_trap        = r_mstatus;
        w_mstatus_trap[7]     = r_mstatus[3];
        w_mstatus_trap[3]     = 1'b0;
        w_mstatus_trap[12:11] = core_mode_q_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mstatus  <= c_MSTATUS_RST;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
        end else if (exception_q_i) begin
            r_mstatus  <= w_mstatus_trap;
            r_mepc     <= mepc_q_i & c_ALIGN_MASK;
            r_mcause   <= mcause_q_i;
            r_mtval    <= mtval_q_i;
        end else begin
            if (w_we_mstatus) r_mstatus <= csr_data_q_i & c_MSTATUS_MASK;
            if (w_we_mepc)    r_mepc    <= csr_data_q_i & c_ALIGN_MASK;
            if (w_we_mcause)  r_mcause  <= csr_data_q_i;
            if (w_we_mtval)   r_mtval   <= csr_data_q_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtvec    <= MTVEC_RST & c_ALIGN_MASK;
            r_mie      <= '0;
            r_mscratch <= '0;
        end else begin
            if (w_we_mtvec)    r_mtvec    <= csr_data_q_i & c_ALIGN_MASK;
            if (w_we_mie)      r_mie      <= csr_data_q_i & c_MIE_MASK;
            if (w_we_mscratch) r_mscratch <= csr_data_q_i;
        end
    end

    // A software write to either half freezes the whole counter for that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcycle <= '0;
        end else if (w_we_mcycle) begin
            r_mcycle[31:0] <= csr_data_q_i[31:0];
        end else if (w_we_mcycleh) begin
            r_mcycle[63:32] <= csr_data_q_i[31:0];
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_minstret <= '0;
        end else if (w_we_minstret) begin
            r_minstret[31:0] <= csr_data_q_i[31:0];
        end else if (w_we_minstreth) begin
            r_minstret[63:32] <= csr_data_q_i[31:0];
        end else if (instret_v_i) begin
            r_minstret <= r_minstret + 64'd1;
        end
    end

    always_comb begin
        w_rd_stored  = '0;
        w_rd_illegal = 1'b0;
        case (csr_rd_adr_i)
            c_ADR_MSTATUS:   w_rd_stored = r_mstatus;
            c_ADR_MISA:      w_rd_stored = c_MISA_VAL;
            c_ADR_MIE:       w_rd_stored = r_mie;
            c_ADR_MTVEC:     w_rd_stored = r_mtvec;
            c_ADR_MSCRATCH:  w_rd_stored = r_mscratch;
            c_ADR_MEPC:      w_rd_stored = r_mepc;
            c_ADR_MCAUSE:    w_rd_stored = r_mcause;
            c_ADR_MTVAL:     w_rd_stored = r_mtval;
            c_ADR_MIP:       w_rd_stored = '0;
            c_ADR_MCYCLE:    w_rd_stored = XLEN'(r_mcycle[31:0]);
            c_ADR_MINSTRET:  w_rd_stored = XLEN'(r_minstret[31:0]);
            c_ADR_MCYCLEH:   w_rd_stored = XLEN'(r_mcycle[63:32]);
            c_ADR_MINSTRETH: w_rd_stored = XLEN'(r_minstret[63:32]);
            c_ADR_MHARTID:   w_rd_stored = c_HART_ID_VAL;
            default:         w_rd_illegal = 1'b1;
        endcase
    end

    // Read-only and unimplemented addresses never bypass, so they keep their fixed value.
    always_comb begin
        w_wb_masked   = '0;
        w_wb_writable = 1'b1;
        case (csr_adr_q_i)
            c_ADR_MSTATUS:   w_wb_masked = csr_data_q_i & c_MSTATUS_MASK;
            c_ADR_MIE:       w_wb_masked = csr_data_q_i & c_MIE_MASK;
            c_ADR_MTVEC,
            c_ADR_MEPC:      w_wb_masked = csr_data_q_i & c_ALIGN_MASK;
            c_ADR_MSCRATCH,
            c_ADR_MCAUSE,
            c_ADR_MTVAL,
            c_ADR_MCYCLE,
            c_ADR_MINSTRET,
            c_ADR_MCYCLEH,
            c_ADR_MINSTRETH: w_wb_masked = csr_data_q_i;
            default:         w_wb_writable = 1'b0;
        endcase
    end

    assign w_bypass_hit     = csr_wbk_v_q_i && w_wb_writable && (csr_adr_q_i == csr_rd_adr_i);
    assign csr_rd_data_o    = w_bypass_hit ? w_wb_masked : w_rd_stored;
    assign csr_rd_illegal_o = w_rd_illegal;

    assign mepc_q_o    = r_mepc;
    assign mtvec_q_o   = r_mtvec;
    assign mstatus_q_o = r_mstatus;

endmodule

`default_nettype wire

// File: tb/tb_csr_file.sv
// ============================================================================
// Module  : tb_csr_file
// Brief   : Directed bench for csr_file with an address-keyed reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_csr_file;

    localparam logic [31:0] c_MTVEC_RST = 32'h8000_0103;
    localparam int          c_HART_ID   = 5;

    logic        clk;
    logic        reset;
    logic [11:0] csr_rd_adr_i;
    logic [31:0] csr_rd_data_o;
    logic        csr_rd_illegal_o;
    logic        csr_wbk_v_q_i;
    logic [11:0] csr_adr_q_i;
    logic [31:0] csr_data_q_i;
    logic        exception_q_i;
    logic [31:0] mcause_q_i;
    logic [31:0] mtval_q_i;
    logic [31:0] mepc_q_i;
    logic [1:0]  core_mode_q_i;
    logic        instret_v_i;
    logic [31:0] mepc_q_o;
    logic [31:0] mtvec_q_o;
    logic [31:0] mstatus_q_o;

    csr_file #(
        .XLEN      (32),
        .MTVEC_RST (c_MTVEC_RST),
        .HART_ID   (c_HART_ID)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .csr_rd_adr_i     (csr_rd_adr_i),
        .csr_rd_data_o    (csr_rd_data_o),
        .csr_rd_illegal_o (csr_rd_illegal_o),
        .csr_wbk_v_q_i    (csr_wbk_v_q_i),
        .csr_adr_q_i      (csr_adr_q_i),
        .csr_data_q_i     (csr_data_q_i),
        .exception_q_i    (exception_q_i),
        .mcause_q_i       (mcause_q_i),
        .mtval_q_i        (mtval_q_i),
        .mepc_q_i         (mepc_q_i),
        .core_mode_q_i    (core_mode_q_i),
        .instret_v_i      (instret_v_i),
        .mepc_q_o         (mepc_q_o),
        .mtvec_q_o        (mtvec_q_o),
        .mstatus_q_o      (mstatus_q_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int r_n_total = 0;
    int r_n_pass  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        r_n_total++;
        if (act === exp) r_n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_csr [int];
    logic [63:0] m_cycle;
    logic [63:0] m_instret;
    bit          m_valid = 1'b0;

    function automatic logic [31:0] wmask(input logic [11:0] a);
        case (a)
            12'h300:                                        return 32'h0000_1888;
            12'h304:                                        return 32'h0000_0888;
            12'h305, 12'h341:                               return 32'hFFFF_FFFC;
            12'h340, 12'h342, 12'h343,
            12'hB00, 12'hB02, 12'hB80, 12'hB82:             return 32'hFFFF_FFFF;
            default:                                        return 32'h0;
        endcase
    endfunction

    function automatic bit implemented(input logic [11:0] a);
        return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF14};
    endfunction

    function automatic logic [31:0] stored(input logic [11:0] a);
        case (a)
            12'h301: return 32'h4000_0100;
            12'hF14: return 32'(c_HART_ID);
            12'hB00: return m_cycle[31:0];
            12'hB80: return m_cycle[63:32];
            12'hB02: return m_instret[31:0];
            12'hB82: return m_instret[63:32];
            default: return m_csr.exists(int'(a)) ? m_csr[int'(a)] : 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] expected_read(input logic [11:0] a);
        logic [31:0] wm;
        wm = wmask(a);
        if (csr_wbk_v_q_i && csr_adr_q_i == a)
            return (csr_data_q_i & wm) | (stored(a) & ~wm);
        return stored(a);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_csr.delete();
            m_csr['h300] = 32'h0000_1800;
            m_csr['h305] = c_MTVEC_RST & 32'hFFFF_FFFC;
            m_csr['h304] = 0; m_csr['h340] = 0; m_csr['h341] = 0;
            m_csr['h342] = 0; m_csr['h343] = 0;
            m_cycle   = 64'd0;
            m_instret = 64'd0;
            m_valid   = 1'b1;
        end else if (m_valid) begin
            logic [63:0] cyc;
            logic [63:0] ins;
            logic [31:0] old_ms;
            cyc = m_cycle + 64'd1;
            ins = m_instret + (instret_v_i ? 64'd1 : 64'd0);
            if (csr_wbk_v_q_i) begin
                case (csr_adr_q_i)
                    12'hB00: cyc = {m_cycle[63:32], csr_data_q_i};
                    12'hB80: cyc = {csr_data_q_i, m_cycle[31:0]};
                    12'hB02: ins = {m_instret[63:32], csr_data_q_i};
                    12'hB82: ins = {csr_data_q_i, m_instret[31:0]};
                    default:
                        if (m_csr.exists(int'(csr_adr_q_i)) &&
                            !(exception_q_i && csr_adr_q_i inside {12'h300, 12'h341, 12'h342, 12'h343}))
                            m_csr[int'(csr_adr_q_i)] = csr_data_q_i & wmask(csr_adr_q_i);
                endcase
            end
            if (exception_q_i) begin
                old_ms = m_csr['h300];
                m_csr['h341] = mepc_q_i & 32'hFFFF_FFFC;
                m_csr['h342] = mcause_q_i;
                m_csr['h343] = mtval_q_i;
                // MIE cleared, MPIE takes old MIE, MPP takes the trapping mode.
                m_csr['h300] = (old_ms[3] ? 32'h80 : 32'h0) | (32'(core_mode_q_i) << 11);
            end
            m_cycle   = cyc;
            m_instret = ins;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_rd_data",    csr_rd_data_o,           expected_read(csr_rd_adr_i));
            check("model_rd_illegal", 32'(csr_rd_illegal_o),   32'(!implemented(csr_rd_adr_i)));
            check("model_mepc_o",     mepc_q_o,                m_csr['h341]);
            check("model_mtvec_o",    mtvec_q_o,               m_csr['h305]);
            check("model_mstatus_o",  mstatus_q_o,             m_csr['h300]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_wbk_v_q_i = 1'b1;
        csr_adr_q_i   = a;
        csr_data_q_i  = d;
        tick();
        csr_wbk_v_q_i = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
        csr_rd_adr_i = a;
        #1;
        check(nm, csr_rd_data_o, exp);
    endtask

    initial begin
        reset         = 1'b1;
        csr_rd_adr_i  = 12'h300;
        csr_wbk_v_q_i = 1'b0;
        csr_adr_q_i   = '0;
        csr_data_q_i  = '0;
        exception_q_i = 1'b0;
        mcause_q_i    = '0;
        mtval_q_i     = '0;
        mepc_q_i      = '0;
        core_mode_q_i = '0;
        instret_v_i   = 1'b0;
        repeat (2) tick();

        @(negedge clk);
        check("rst_mstatus_o", mstatus_q_o, 32'h0000_1800);
        check("rst_mtvec_o",   mtvec_q_o,   32'h8000_0100);
        rd_chk("rst_rd_mstatus", 12'h300, 32'h0000_1800);
        rd_chk("rst_rd_mtvec",   12'h305, 32'h8000_0100);
        rd_chk("rst_rd_mcycle",  12'hB00, 32'h0);
        tick();
        reset = 1'b0;

        // Bypass and WARL masking of mstatus
        csr_wbk_v_q_i = 1'b1; csr_adr_q_i = 12'h300; csr_data_q_i = 32'hFFFF_FFFF;
        csr_rd_adr_i  = 12'h300;
        @(negedge clk);
        check("bypass_mstatus", csr_rd_data_o, 32'h0000_1888);
        tick();
        csr_wbk_v_q_i = 1'b0;
        @(negedge clk);
        check("mstatus_after_wr", csr_rd_data_o, 32'h0000_1888);
        check("mstatus_o_after_wr", mstatus_q_o, 32'h0000_1888);
        tick();

        // Trap with a simultaneous mepc write: trap wins
        wr(12'h300, 32'h0000_0008);
        exception_q_i = 1'b1; mepc_q_i = 32'h103; mcause_q_i = 32'd2;
        mtval_q_i = 32'hDEAD; core_mode_q_i = 2'd3;
        wr(12'h341, 32'h55);
        exception_q_i = 1'b0;
        @(negedge clk);
        check("trap_mstatus_o", mstatus_q_o, 32'h0000_1880);
        check("trap_mepc_o",    mepc_q_o,    32'h0000_0100);
        rd_chk("trap_rd_mcause", 12'h342, 32'd2);
        rd_chk("trap_rd_mtval",  12'h343, 32'hDEAD);
        tick();

        // Trap with a simultaneous mscratch write: the write still commits
        exception_q_i = 1'b1; mepc_q_i = 32'h2002; mcause_q_i = 32'h8000_000B;
        mtval_q_i = 32'h77; core_mode_q_i = 2'd0;
        wr(12'h340, 32'hCAFE_BABE);
        exception_q_i = 1'b0;
        @(negedge clk);
        check("trap2_mstatus_o", mstatus_q_o, 32'h0000_0000);
        check("trap2_mepc_o",    mepc_q_o,    32'h0000_2000);
        rd_chk("trap2_mscratch", 12'h340, 32'hCAFE_BABE);
        tick();

        // Remaining WARL registers
        wr(12'h304, 32'hFFFF_FFFF);
        wr(12'h305, 32'h1234_5677);
        @(negedge clk);
        rd_chk("warl_mie",   12'h304, 32'h0000_0888);
        rd_chk("warl_mtvec", 12'h305, 32'h1234_5674);
        check("warl_mtvec_o", mtvec_q_o, 32'h1234_5674);
        tick();

        // Low-to-high carry of mcycle
        wr(12'hB00, 32'hFFFF_FFFF);
        @(negedge clk);
        rd_chk("mcycle_lo_wr", 12'hB00, 32'hFFFF_FFFF);
        rd_chk("mcycle_hi_wr", 12'hB80, 32'h0);
        tick();
        @(negedge clk);
        rd_chk("mcycle_lo_carry", 12'hB00, 32'h0);
        rd_chk("mcycle_hi_carry", 12'hB80, 32'h1);
        tick();

        // Full 64-bit wrap
        wr(12'hB80, 32'hFFFF_FFFF);
        wr(12'hB00, 32'hFFFF_FFFF);
        @(negedge clk);
        rd_chk("mcycle_hi_max", 12'hB80, 32'hFFFF_FFFF);
        tick();
        @(negedge clk);
        rd_chk("mcycle_lo_wrap", 12'hB00, 32'h0);
        rd_chk("mcycle_hi_wrap", 12'hB80, 32'h0);
        tick();

        // minstret counts retired instructions only
        instret_v_i = 1'b1;
        repeat (5) tick();
        instret_v_i = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        rd_chk("minstret_5",  12'hB02, 32'd5);
        rd_chk("minstreth_0", 12'hB82, 32'd0);
        tick();

        // Read-only and unimplemented addresses
        csr_rd_adr_i = 12'hF14;
        wr(12'hF14, 32'h1234);
        wr(12'h301, 32'h0);
        wr(12'h344, 32'hFFFF_FFFF);
        wr(12'h7C0, 32'hFFFF_FFFF);
        @(negedge clk);
        rd_chk("ro_mhartid", 12'hF14, 32'd5);
        rd_chk("ro_misa",    12'h301, 32'h4000_0100);
        rd_chk("ro_mip",     12'h344, 32'h0);
        check("mip_legal", 32'(csr_rd_illegal_o), 32'h0);
        tick();
        @(negedge clk);
        rd_chk("unimpl_data", 12'h7C0, 32'h0);
        check("unimpl_illegal", 32'(csr_rd_illegal_o), 32'h1);
        tick();
        repeat (2) tick();

        $display("%0d/%0d checks passed", r_n_pass, r_n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- XLEN, 32, data width.
- MTVEC_RST, 32'h0000_0000, mtvec value after reset.
- HART_ID, 0, value returned by mhartid.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, synchronous, active-high reset.
- csr_rd_adr_i, in, 12, decode-stage CSR read address.
- csr_rd_data_o, out, XLEN, read data; combinational.
- csr_rd_illegal_o, out, 1, read address not implemented; combinational.
- csr_wbk_v_q_i, in, 1, write-back valid from execute.
- csr_adr_q_i, in, 12, write-back CSR address.
- csr_data_q_i, in, XLEN, write-back CSR data.
- exception_q_i, in, 1, trap taken this cycle.
- mcause_q_i, in, XLEN, trap cause.
- mtval_q_i, in, XLEN, trap value.
- mepc_q_i, in, XLEN, trapping PC.
- core_mode_q_i, in, 2, privilege mode at trap.
- instret_v_i, in, 1, one instruction retired this cycle.
- mepc_q_o, out, XLEN, current mepc.
- mtvec_q_o, out, XLEN, current mtvec.
- mstatus_q_o, out, XLEN, current mstatus.

Function
REQ-003 Implemented addresses: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, mhartid 0xF14.
REQ-004 Unimplemented read address: csr_rd_data_o=0, csr_rd_illegal_o=1; implemented address: csr_rd_illegal_o=0.
REQ-005 Read bypass: csr_wbk_v_q_i=1 with csr_adr_q_i==csr_rd_adr_i returns the WARL-masked write data in the same cycle, not the stored value.
REQ-006 Read-only registers:
- misa reads 32'h4000_0100.
- mhartid reads HART_ID.
- mip reads 0.
- Writes to these, and to any unimplemented address, are ignored with no side effect.
REQ-007 WARL masks:
- mstatus: only bits 3 (MIE), 7 (MPIE) and 12:11 (MPP) are stored; all other bits read 0.
- mtvec[1:0] and mepc[1:0] are forced to 0.
- mie: only bits 3, 7 and 11 are stored.
- mscratch, mcause and mtval store the full word.
REQ-008 Writes commit at the rising edge when csr_wbk_v_q_i=1; the write becomes visible to reads in the next cycle (see REQ-005 for same-cycle bypass).
REQ-009 Trap entry when exception_q_i=1, in one edge:
- mepc <= mepc_q_i with [1:0] forced to 0.
- mcause <= mcause_q_i.
- mtval <= mtval_q_i.
- mstatus.MPIE <= MIE, mstatus.MIE <= 0, mstatus.MPP <= core_mode_q_i.
REQ-010 Same-cycle exception_q_i and software write to mstatus, mepc, mcause or mtval: trap update wins and the software write to those four registers is dropped; writes to any other CSR still commit.
REQ-011 mcycle (64-bit, {mcycleh, mcycle}) increments by 1 every cycle when reset=0 and wraps from 2^64-1 to 0.
REQ-012 minstret (64-bit) increments by 1 when instret_v_i=1 and wraps from 2^64-1 to 0.
REQ-013 Counter write precedence: a software write to a counter half replaces that half for that edge and suppresses the increment of the whole 64-bit counter in that cycle; the other half is unchanged.
REQ-014 Carry propagates from the low to the high half in the same edge; no extra cycle of latency.
REQ-015 mepc_q_o, mtvec_q_o and mstatus_q_o are driven directly from the stored registers, with no bypass.

Reset
REQ-016 With reset=1 at a rising edge, the following reset values apply:
- mstatus = 32'h0000_1800 (MPP=11).
- mtvec = MTVEC_RST with [1:0] forced to 0.
- All other writable CSRs and both counters = 0.
REQ-017 Reset has priority over exception_q_i, csr_wbk_v_q_i and counter increment. The first increment of mcycle occurs at the first edge with reset=0.

Verification
REQ-018 Reset, then read mstatus, mtvec, mcycle -> 0x0000_1800, MTVEC_RST, 0; outputs match these values at reset.
REQ-019 Write 0xFFFF_FFFF to mstatus, then read it -> 0x0000_1888; same-cycle read of 0x300 with the write -> 0x0000_1888 via bypass.
REQ-020 Sequence with mstatus=0x8, then exception_q_i=1, mepc_q_i=0x103, mcause_q_i=2, core_mode_q_i=3, plus a simultaneous write of 0x55 to mepc:
- mepc = 0x100, mcause = 2.
- mstatus = 0x1880.
REQ-021 Write 0xFFFF_FFFF to mcycle with mcycleh=0, then run idle:
- Cycle after the write: mcycle=0xFFFF_FFFF, mcycleh=0.
- One cycle later: mcycle=0, mcycleh=1.
REQ-022 Boundary and read-only checks:
- Read 0x7C0 -> data 0, illegal=1.
- Write to 0xF14 or 0x301 -> values unchanged.
- minstret with instret_v_i high for 5 cycles -> reads 5.
